regfile_wb_arbiter: RTL

Write-back arbiter and scoreboard for the 4-entry × 16-bit processor register file. The register file has one write port; this block shares it between two producers, the ALU and the memory load unit, using valid/ready handshakes and round-robin priority. It drives the register file's `in`/`inSel`/`inEn` from registered outputs. It also keeps a per-register busy scoreboard so decode can detect pending writes (RAW) and block WAW issue.

---
 rtl/regfile_wb_arbiter.sv | 54 +++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin ALU/load write-back arbiter for the register file with a busy scoreboard
module regfile_wb_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aluValid,
  output logic              aluReady,
  input  logic [DATA_W-1:0] aluData,
  input  logic [1:0]        aluSel,
  input  logic              memValid,
  output logic              memReady,
  input  logic [DATA_W-1:0] memData,
  input  logic [1:0]        memSel,
  input  logic              issueEn,
  input  logic [1:0]        issueSel,
  output logic              issueStall,
  output logic [3:0]        busy,
  output logic [DATA_W-1:0] rfIn,
  output logic [1:0]        rfInSel,
  output logic              rfInEn
);
  logic       last_grant;
  logic       grant_alu;
  logic       grant_mem;
  logic [3:0] busy_next;
  // a tie goes to whichever requester was not granted last
  always_comb begin
    grant_alu  = aluValid & (~memValid | last_grant);
    grant_mem  = memValid & (~aluValid | ~last_grant);
    issueStall = issueEn & busy[issueSel];
    busy_next  = (busy & ~(rfInEn ? 4'b0001 << rfInSel : 4'b0000))
               | ((issueEn & ~issueStall) ? 4'b0001 << issueSel : 4'b0000);
  end
  assign aluReady = grant_alu;
  assign memReady = grant_mem;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rfIn       <= '0;
      rfInSel    <= '0;
      rfInEn     <= 1'b0;
      last_grant <= 1'b1;
      busy       <= '0;
    end else begin
      rfInEn <= grant_alu | grant_mem;
      if (grant_alu | grant_mem) begin
        rfIn       <= grant_alu ? aluData : memData;
        rfInSel    <= grant_alu ? aluSel : memSel;
        last_grant <= grant_mem;
      end
      busy <= busy_next;
    end
  end
endmodule
